// File: rtl/audio_pkg.sv
// Shared types, widths and the note table for the tone generator.
// Note half-periods are given in clocks at a 50 MHz reference.
package audio_pkg;

  typedef enum logic [1:0] {
    SILENT,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int HALF_PERIOD_W = 17;
  localparam int AMP_W = 4;
  localparam longint REF_HZ = 50_000_000;

  localparam logic [HALF_PERIOD_W-1:0] NOTE_HALF_PERIOD [16] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353,
    17'd75843, 17'd71586, 17'd67568, 17'd63776,
    17'd60196, 17'd56818, 17'd53629, 17'd50619,
    17'd47778, 17'd45097, 17'd42566, 17'd40177
  };

  // Rescales the reference table to another clock; identity at 50 MHz.
  function automatic logic [HALF_PERIOD_W-1:0] half_period(
    input logic [3:0] code,
    input longint clk_hz
  );
    longint hp;
    hp = longint'(NOTE_HALF_PERIOD[code]) * clk_hz / REF_HZ;
    if (hp < 1) hp = 1;
    return HALF_PERIOD_W'(hp);
  endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Note request link from the audio controller to the tone generator.
interface tone_generator_if;
  logic       EnableSound;
  logic [3:0] frequency;

  modport master (
    output EnableSound,
    output frequency
  );

  modport slave (
    input EnableSound,
    input frequency
  );
endinterface

// File: rtl/tone_generator_osc.sv
// Square-wave oscillator: half-period down-counter with reload
// from the pending note only at a phase toggle.
module tone_osc
  import audio_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] code,
  output logic       phase
);

  logic [HALF_PERIOD_W-1:0] tab [16];
  logic [HALF_PERIOD_W-1:0] cnt;
  logic                     running;

  for (genvar i = 0; i < 16; i++) begin : g_tab
    assign tab[i] = half_period(4'(i), longint'(CLK_HZ))
                  - HALF_PERIOD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      phase   <= 1'b0;
      running <= 1'b0;
    end else begin
      running <= run;
      if (!run) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (!running) begin
        cnt   <= tab[code];
        phase <= 1'b1;
      end else if (cnt == '0) begin
        cnt   <= tab[code];
        phase <= ~phase;
      end else begin
        cnt <= cnt - HALF_PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_generator.sv
// Note-table tone generator with attack/release envelope and
// registered PCM / square outputs.
module tone_generator
  import audio_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int ENV_STEP_CYCLES = 50_000,
  parameter int AMP_SHIFT       = 11
) (
  input  logic                clk,
  input  logic                reset,
  tone_generator_if.slave     req,
  output logic signed [15:0]  sample_out,
  output logic                square_out,
  output logic                busy
);

  localparam int STEP_W = $clog2(ENV_STEP_CYCLES + 1);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(ENV_STEP_CYCLES - 1);

  env_state_t        state, state_nxt;
  logic [AMP_W-1:0]  amp, amp_nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [3:0]        code;
  logic [3:0]        pend;
  logic              step;
  logic              phase;
  logic              en;
  logic signed [15:0] mag;

  assign en   = req.EnableSound;
  assign pend = en ? req.frequency : code;
  assign step = (state != SILENT) && (step_cnt == '0);
  assign mag  = 16'(amp) << AMP_SHIFT;

  tone_osc #(
    .CLK_HZ(CLK_HZ)
  ) u_osc (
    .clk  (clk),
    .reset(reset),
    .run  (state_nxt != SILENT),
    .code (pend),
    .phase(phase)
  );

  always_comb begin
    state_nxt = state;
    amp_nxt   = amp;
    unique case (state)
      SILENT: begin
        if (en) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!en) begin
          state_nxt = RELEASE;
        end else if (amp == '1) begin
          state_nxt = SUSTAIN;
        end else if (step) begin
          amp_nxt = amp + AMP_W'(1);
          if (amp == AMP_W'(14)) state_nxt = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (!en) state_nxt = RELEASE;
      end
      RELEASE: begin
        // retrigger resumes the ramp from the current amplitude
        if (en) begin
          state_nxt = ATTACK;
        end else if (amp == '0) begin
          state_nxt = SILENT;
        end else if (step) begin
          amp_nxt = amp - AMP_W'(1);
          if (amp == AMP_W'(1)) state_nxt = SILENT;
        end
      end
      default: state_nxt = SILENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SILENT;
      amp        <= '0;
      code       <= '0;
      step_cnt   <= STEP_LOAD;
      sample_out <= '0;
      square_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      amp   <= amp_nxt;
      if (en) code <= req.frequency;
      if (state == SILENT) step_cnt <= STEP_LOAD;
      else step_cnt <= step ? STEP_LOAD : step_cnt - STEP_W'(1);
      sample_out <= phase ? mag : -mag;
      square_out <= phase;
      busy       <= (state != SILENT);
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: a cycle model pushes expected
// outputs each edge, and they are popped and compared on the falling edge.
module tb_tone_generator;

  localparam int CLK_HZ = 5_000_000;
  localparam int ENV    = 4;
  localparam int SHIFT  = 11;
  localparam longint REF = 50_000_000;
  localparam int NOTE [16] = '{
    95556, 90193, 85131, 80353, 75843, 71586, 67568, 63776,
    60196, 56818, 53629, 50619, 47778, 45097, 42566, 40177
  };

  bit clk = 1'b0;
  logic reset;
  logic signed [15:0] sample_out;
  logic square_out;
  logic busy;

  tone_generator_if bus ();

  tone_generator #(
    .CLK_HZ         (CLK_HZ),
    .ENV_STEP_CYCLES(ENV),
    .AMP_SHIFT      (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.slave),
    .sample_out(sample_out),
    .square_out(square_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_q [$];

  int m_st, m_amp, m_cnt, m_stc, m_code;
  bit m_ph;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hp(int c);
    return int'(longint'(NOTE[c]) * CLK_HZ / REF);
  endfunction

  // reference model
  always @(posedge clk) begin
    int nst, namp, pend;
    bit step, en;
    logic [17:0] e;
    en = bus.EnableSound;
    if (reset) begin
      m_st = 0; m_amp = 0; m_ph = 0; m_cnt = 0;
      m_code = 0; m_stc = ENV - 1;
      e = '0;
    end else begin
      e = {m_st != 0, m_ph,
           16'(m_ph ? (m_amp << SHIFT) : -(m_amp << SHIFT))};
      pend = en ? int'(bus.frequency) : m_code;
      step = (m_st != 0) && (m_stc == 0);
      nst = m_st;
      namp = m_amp;
      case (m_st)
        0: if (en) nst = 1;
        1: if (!en) nst = 3;
           else if (m_amp == 15) nst = 2;
           else if (step) begin
             namp = m_amp + 1;
             if (namp == 15) nst = 2;
           end
        2: if (!en) nst = 3;
        default: if (en) nst = 1;
           else if (m_amp == 0) nst = 0;
           else if (step) begin
             namp = m_amp - 1;
             if (namp == 0) nst = 0;
           end
      endcase
      if (nst == 0) begin
        m_ph = 0; m_cnt = 0;
      end else if (m_st == 0) begin
        m_ph = 1; m_cnt = hp(int'(bus.frequency)) - 1;
      end else if (m_cnt == 0) begin
        m_ph = !m_ph; m_cnt = hp(pend) - 1;
      end else begin
        m_cnt--;
      end
      if (m_st == 0 || step) m_stc = ENV - 1;
      else m_stc--;
      if (en) m_code = int'(bus.frequency);
      m_st = nst;
      m_amp = namp;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb", {14'd0, busy, square_out, sample_out}, {14'd0, e});
    end
  end

  task automatic wait_tog(output int n);
    logic p;
    p = square_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (square_out == p && n < 20000);
    if (n >= 20000) check("tog_timeout", n, 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && busy; k++) @(negedge clk);
    check("idle", busy, 0);
  endtask

  function automatic int mag(logic signed [15:0] s);
    return (s < 0) ? -int'(s) : int'(s);
  endfunction

  initial begin
    int n, k;
    reset = 1'b1;
    bus.EnableSound = 1'b0;
    bus.frequency = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sq", square_out, 0);
    check("rst_smp", int'(sample_out), 0);
    reset = 1'b0;

    // attack on A4, then check both half-period lengths and peaks
    bus.frequency = 4'd9;
    bus.EnableSound = 1'b1;
    repeat (70) @(negedge clk);
    check("peak_pos", int'(sample_out), 30720);
    check("att_busy", busy, 1);
    wait_tog(n);
    repeat (10) @(negedge clk);
    check("peak_neg", int'(sample_out), -30720);
    wait_tog(n);
    check("hp_a4", 10 + n, 5681);

    // note change mid half-period
    repeat (1000) @(negedge clk);
    bus.frequency = 4'd0;
    wait_tog(n);
    check("hp_nochop", 1000 + n, 5681);
    wait_tog(n);
    check("hp_c4", n, 9555);

    // release; code change is ignored while disabled
    bus.EnableSound = 1'b0;
    bus.frequency = 4'd3;
    repeat (70) @(negedge clk);
    check("rel_busy", busy, 0);
    check("rel_smp", int'(sample_out), 0);
    check("rel_sq", square_out, 0);

    // retrigger during release at amp 7
    bus.frequency = 4'd5;
    bus.EnableSound = 1'b1;
    repeat (70) @(negedge clk);
    bus.EnableSound = 1'b0;
    for (k = 0; k < 100 && m_amp != 7; k++) @(negedge clk);
    check("reach7", m_amp, 7);
    bus.EnableSound = 1'b1;
    repeat (2) @(negedge clk);
    check("retrig_amp", mag(sample_out), 7 << SHIFT);
    repeat (40) @(negedge clk);
    check("retrig_peak", mag(sample_out), 30720);

    // drop on the same cycle as an attack step at amp 5
    bus.EnableSound = 1'b0;
    wait_idle();
    bus.frequency = 4'd2;
    bus.EnableSound = 1'b1;
    for (k = 0; k < 200 && !(m_st == 1 && m_amp == 5 && m_stc == 0); k++)
      @(negedge clk);
    check("reach5", m_amp, 5);
    bus.EnableSound = 1'b0;
    repeat (2) @(negedge clk);
    check("simul_hold", mag(sample_out), 5 << SHIFT);
    check("simul_busy", busy, 1);
    repeat (4) @(negedge clk);
    check("simul_dec", mag(sample_out), 4 << SHIFT);

    // reset mid-sustain, then restart from amp 0
    wait_idle();
    bus.frequency = 4'd9;
    bus.EnableSound = 1'b1;
    repeat (70) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_busy", busy, 0);
    check("rst2_sq", square_out, 0);
    check("rst2_smp", int'(sample_out), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("restart", int'(sample_out), 2048);

    bus.EnableSound = 1'b0;
    repeat (100) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
